// File: rtl/rom_writer.sv
// -----------------------------------------------------------------------------
// rom_writer
//
// Programs one word of a bipolar fuse PROM (3601 / 556PT4 class) per host
// command. Each requested bit is blown individually with a timed program
// strobe. After each strobe the chip is read back, and a bit that does not
// take gets a bounded number of extra pulses.
//
// Ports
//   clk, reset            : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : host command handshake (see note below)
//   cmd_address/cmd_data  : target address and word (1 = blow fuse)
//   address_line          : chip address, holds the last latched address
//   chip_select_n         : active-low chip select, low while the chip is in use
//   data_line_in          : chip read-back data
//   program_enable        : gates the programming supply, high only in PULSE
//   program_bit           : one-hot bit currently being blown, else zero
//   done / error          : one-cycle completion pulses
//   fail_mask             : offending bits, valid from error until next accept
//   last_read             : last word sampled from the chip
//   dbg_state             : current FSM state, for debug and checkers
//
// Handshake: a command is taken on any rising edge where cmd_valid and
// cmd_ready are both high and reset is low. cmd_ready is high only in IDLE.
// cmd_valid seen while busy is ignored, so the host must hold address/data
// stable with cmd_valid high until it sees cmd_ready.
// -----------------------------------------------------------------------------
module rom_writer #(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int PULSE_CYCLES  = 50,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic                     chip_select_n,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic                     program_enable,
  output logic [DATA_WIDTH-1:0]    program_bit,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    fail_mask,
  output logic [DATA_WIDTH-1:0]    last_read,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_EVAL    = 3'd2,
    ST_PULSE   = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  // One shared cycle counter serves SETTLE, PULSE and RECOVER, so it is sized
  // for the longer of the two timed intervals.
  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  // The attempt counter must be able to hold MAX_RETRIES+1.
  localparam int ATT_W   = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT   = ATT_W'(MAX_RETRIES);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ATT_W-1:0]         att_q, att_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [DATA_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]    last_read_q, last_read_d;
  logic [DATA_WIDTH-1:0]    fail_mask_q, fail_mask_d;
  logic                     pe_q, pe_d;
  logic [DATA_WIDTH-1:0]    pbit_q, pbit_d;
  logic                     cs_n_q, cs_n_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic [DATA_WIDTH-1:0]    conflict;
  logic [DATA_WIDTH-1:0]    need;

  // Bits already blown that the word does not want can never be undone.
  assign conflict = last_read_q & ~data_q;
  // Bits the word wants that still read blank.
  assign need     = data_q & ~last_read_q;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    att_d       = att_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    last_read_d = last_read_q;
    fail_mask_d = fail_mask_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_address;
          data_d      = cmd_data;
          fail_mask_d = '0;
          cnt_d       = '0;
          att_d       = '0;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          last_read_d = data_line_in;
          cnt_d       = '0;
          state_d     = ST_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_EVAL: begin
        if (conflict != '0) begin
          fail_mask_d = conflict;
          state_d     = ST_ERROR;
        end else if (need == '0) begin
          state_d = ST_DONE;
        end else begin
          // Two's-complement trick isolates the lowest set bit of need.
          sel_d   = need & (~need + DATA_WIDTH'(1));
          cnt_d   = '0;
          state_d = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECOVER: begin
        if (cnt_q == SETTLE_LAST) begin
          last_read_d = data_line_in;
          cnt_d       = '0;
          if ((data_line_in & sel_q) != '0) begin
            // Bit took; re-evaluate the whole word, which also catches any
            // neighbouring fuse that blew by accident.
            att_d   = '0;
            state_d = ST_EVAL;
          end else if (att_q < ATT_LIMIT) begin
            att_d   = att_q + ATT_W'(1);
            state_d = ST_PULSE;
          end else begin
            // Out of retries; the remaining bits are abandoned.
            att_d       = att_q + ATT_W'(1);
            fail_mask_d = sel_q;
            state_d     = ST_ERROR;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;

      default:  state_d = ST_IDLE;
    endcase
  end

  // Chip-facing outputs are registered from the next state so they line up
  // exactly with the state they belong to and cannot glitch.
  always_comb begin
    pe_d    = (state_d == ST_PULSE);
    pbit_d  = (state_d == ST_PULSE) ? sel_d : '0;
    cs_n_d  = !((state_d == ST_SETTLE) || (state_d == ST_EVAL) ||
                (state_d == ST_PULSE)  || (state_d == ST_RECOVER));
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      att_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      last_read_q <= '0;
      fail_mask_q <= '0;
      pe_q        <= 1'b0;
      pbit_q      <= '0;
      cs_n_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      att_q       <= att_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      last_read_q <= last_read_d;
      fail_mask_q <= fail_mask_d;
      pe_q        <= pe_d;
      pbit_q      <= pbit_d;
      cs_n_q      <= cs_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready      = (state_q == ST_IDLE);
  assign address_line   = addr_q;
  assign chip_select_n  = cs_n_q;
  assign program_enable = pe_q;
  assign program_bit    = pbit_q;
  assign done           = done_q;
  assign error          = error_q;
  assign fail_mask      = fail_mask_q;
  assign last_read      = last_read_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rom_writer.sv
// -----------------------------------------------------------------------------
// tb_rom_writer
//
// Bench for rom_writer. A single-word fuse chip model answers reads and blows
// bits while the strobe is applied. A reference task works out the expected
// outcome, completion cycle and pulse sequence from the word-level rules.
// -----------------------------------------------------------------------------
module tb_rom_writer;

  localparam int S = 4;
  localparam int P = 50;
  localparam int R = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_address;
  logic [3:0] cmd_data;
  logic [7:0] address_line;
  logic       chip_select_n;
  logic [3:0] data_line_in;
  logic       program_enable;
  logic [3:0] program_bit;
  logic       done;
  logic       error;
  logic [3:0] fail_mask;
  logic [3:0] last_read;
  logic [2:0] dbg_state;

  rom_writer #(
    .DATA_WIDTH(4), .ADDRESS_WIDTH(8), .SETTLE_CYCLES(S),
    .PULSE_CYCLES(P), .MAX_RETRIES(R)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .address_line(address_line), .chip_select_n(chip_select_n),
    .data_line_in(data_line_in),
    .program_enable(program_enable), .program_bit(program_bit),
    .done(done), .error(error),
    .fail_mask(fail_mask), .last_read(last_read),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Chip model: one word, with stuck bits that never blow and "extra" bits that
  // blow along with any successful blow.
  // ---------------------------------------------------------------------------
  logic [3:0] chip_word = 4'h0;
  logic       chip_load = 1'b0;
  logic [3:0] chip_load_val = 4'h0;
  logic [3:0] stuck_mask = 4'h0;
  logic [3:0] extra_mask = 4'h0;

  assign data_line_in = chip_word;

  always @(posedge clk) begin
    if (chip_load)
      chip_word <= chip_load_val;
    else if (program_enable && !chip_select_n && ((program_bit & ~stuck_mask) != 4'h0))
      chip_word <= chip_word | (program_bit & ~stuck_mask) | extra_mask;
  end

  // ---------------------------------------------------------------------------
  // Strobe / address monitor
  // ---------------------------------------------------------------------------
  logic       mon_rst = 1'b1;
  logic [7:0] exp_addr = 8'h00;
  int         pulse_n, width_bad, gap_bad, addr_bad, run_len, low_run;
  logic [3:0] pulse_bits [16];
  logic [3:0] cur_bit;
  logic       pe_prev;

  always @(negedge clk) begin
    if (mon_rst) begin
      pulse_n = 0; width_bad = 0; gap_bad = 0; addr_bad = 0;
      run_len = 0; low_run = 0; pe_prev = 1'b0; cur_bit = 4'h0;
    end else begin
      if (!chip_select_n && address_line !== exp_addr) addr_bad++;
      if (program_enable && chip_select_n) gap_bad++;
      if (program_enable) begin
        if (!pe_prev) begin
          if (pulse_n > 0 && low_run < S) gap_bad++;
          if (pulse_n < 16) pulse_bits[pulse_n] = program_bit;
          pulse_n++;
          run_len = 1;
          cur_bit = program_bit;
        end else begin
          run_len++;
          if (program_bit !== cur_bit) width_bad++;
        end
      end else begin
        if (pe_prev) begin
          if (run_len != P) width_bad++;
          low_run = 1;
        end else begin
          low_run++;
        end
        if (program_bit !== 4'h0) width_bad++;
      end
      pe_prev = program_enable;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: walk the word's bits in ascending order, lowest blank wanted bit
  // first, re-checking the whole word after every successful blow.
  task automatic model(input logic [3:0] w0, input logic [3:0] d,
                       input logic [3:0] stuck, input logic [3:0] extra,
                       output bit e_done, output int e_cyc,
                       output logic [3:0] e_fm, output logic [3:0] e_lr);
    logic [3:0] word;
    logic [3:0] b;
    int i;
    bit fin;
    exp_q.delete();
    word = w0; e_cyc = S + 2; e_fm = 4'h0; e_done = 0; fin = 0;
    while (!fin) begin
      if ((word & ~d) != 4'h0) begin
        e_fm = word & ~d; fin = 1;
      end else if ((d & ~word) == 4'h0) begin
        e_done = 1; fin = 1;
      end else begin
        i = 0;
        while (!(d[i] && !word[i])) i++;
        b = 4'h1 << i;
        if (stuck[i]) begin
          for (int k = 0; k <= R; k++) exp_q.push_back(b);
          e_cyc += (R + 1) * (P + S);
          e_fm = b;
          fin = 1;
        end else begin
          exp_q.push_back(b);
          e_cyc += P + S + 1;
          word = word | b | extra;
        end
      end
    end
    e_lr = word;
  endtask

  // Prepare the chip and monitor for a new operation at address a.
  task automatic setup_op(input logic [7:0] a, input logic [3:0] w0,
                          input logic [3:0] stuck, input logic [3:0] extra);
    tick();
    mon_rst = 1'b1; chip_load = 1'b1; chip_load_val = w0;
    exp_addr = a; stuck_mask = stuck; extra_mask = extra;
    tick();
    mon_rst = 1'b0; chip_load = 1'b0;
  endtask

  // Count cycles from cycle 1 until done/error, bounded.
  task automatic wait_result(output bit got, output int cyc);
    cyc = 1; got = 0;
    while (!got && cyc < 3000) begin
      if (done || error) got = 1;
      else begin tick(); cyc++; end
    end
  endtask

  task automatic run_op(input string nm, input logic [7:0] a, input logic [3:0] d,
                        input logic [3:0] w0, input logic [3:0] stuck,
                        input logic [3:0] extra);
    bit e_done, got;
    int e_cyc, cyc, w;
    logic [3:0] e_fm, e_lr;
    model(w0, d, stuck, extra, e_done, e_cyc, e_fm, e_lr);
    setup_op(a, w0, stuck, extra);
    w = 0;
    while (!cmd_ready && w < 100) begin tick(); w++; end
    check({nm, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_address = a; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    wait_result(got, cyc);
    check({nm, "_timeout"}, got, 1);
    check({nm, "_outcome"}, {done, error}, {e_done, !e_done});
    check({nm, "_cycle"}, cyc, e_cyc);
    check({nm, "_fail_mask"}, fail_mask, e_fm);
    check({nm, "_last_read"}, last_read, e_lr);
    check({nm, "_cs_n_end"}, chip_select_n, 1);
    check({nm, "_pulse_count"}, pulse_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pulse_n && i < 16; i++)
      check({nm, "_pulse_bit"}, pulse_bits[i], exp_q[i]);
    check({nm, "_pulse_width"}, width_bad, 0);
    check({nm, "_pulse_gap"}, gap_bad, 0);
    check({nm, "_address"}, addr_bad, 0);
    tick();
    check({nm, "_one_cycle"}, {done, error}, 2'b00);
    check({nm, "_ready_after"}, cmd_ready, 1);
    check({nm, "_addr_hold"}, address_line, a);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit got;
    int cyc, seen;
    logic [3:0] w0, d, st;

    reset = 1'b1; cmd_valid = 1'b1; cmd_address = 8'hFF; cmd_data = 4'hF;
    repeat (3) tick();
    // cmd_valid held during reset must not be taken.
    check("rst_ready", cmd_ready, 1);
    check("rst_addr", address_line, 8'h00);
    check("rst_cs_n", chip_select_n, 1);
    check("rst_pe", program_enable, 0);
    check("rst_pbit", program_bit, 4'h0);
    check("rst_done_err", {done, error}, 2'b00);
    check("rst_fail_mask", fail_mask, 4'h0);
    check("rst_last_read", last_read, 4'h0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();

    run_op("blank_match", 8'h00, 4'h0, 4'h0, 4'h0, 4'h0);
    run_op("two_bit",     8'h2A, 4'h5, 4'h0, 4'h0, 4'h0);
    run_op("stuck_bit",   8'h11, 4'h8, 4'h0, 4'h8, 4'h0);
    run_op("precheck",    8'h22, 4'h1, 4'h3, 4'h0, 4'h0);
    run_op("extra_blow",  8'h44, 4'h1, 4'h0, 4'h0, 4'h4);
    run_op("full_word",   8'hFF, 4'hF, 4'h0, 4'h0, 4'h0);

    // Reset in the middle of the first pulse.
    setup_op(8'h33, 4'h0, 4'h0, 4'h0);
    cmd_valid = 1'b1; cmd_address = 8'h33; cmd_data = 4'h5;
    tick();
    cmd_valid = 1'b0;
    repeat (S + 20) tick();
    check("midrst_pe_before", program_enable, 1);
    check("midrst_pbit_before", program_bit, 4'h1);
    reset = 1'b1;
    tick();
    check("midrst_pe", program_enable, 0);
    check("midrst_pbit", program_bit, 4'h0);
    check("midrst_cs_n", chip_select_n, 1);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_done_err", {done, error}, 2'b00);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done || error || program_enable) seen++;
    end
    check("midrst_quiet", seen, 0);
    run_op("after_reset", 8'h34, 4'h5, 4'h0, 4'h0, 4'h0);

    // Back-to-back: cmd_valid held high across two words at one address.
    setup_op(8'h5A, 4'h0, 4'h0, 4'h0);
    cmd_valid = 1'b1; cmd_address = 8'h5A; cmd_data = 4'h1;
    tick();
    cmd_data = 4'h3;
    wait_result(got, cyc);
    check("b2b_first_timeout", got, 1);
    check("b2b_first_done", {done, error}, 2'b10);
    check("b2b_first_cycle", cyc, S + 2 + (P + S + 1));
    check("b2b_ready_in_done", cmd_ready, 0);
    tick();
    check("b2b_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wait_result(got, cyc);
    check("b2b_second_timeout", got, 1);
    check("b2b_second_done", {done, error}, 2'b10);
    check("b2b_second_cycle", cyc, S + 2 + (P + S + 1));
    check("b2b_last_read", last_read, 4'h3);
    tick();

    // Random words against the reference.
    for (int n = 0; n < 30; n++) begin
      w0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      d  = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 4) == 0) ? (4'h1 << $urandom_range(0, 3)) : 4'h0;
      run_op("random", 8'($urandom_range(0, 255)), d, w0, st, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
